dmem_lsu: RTL and testbench

- Load/store initiator that drives the data memory port (byte address, write data, byte enables, async read data) on behalf of the core.
- Takes one byte, halfword or word request at a time over a valid/ready handshake and converts it to byte-lane enables and shifted write data.
- Splits accesses that cross a word boundary into two memory cycles.
- Merges read data, sign- or zero-extends it, and returns a response over a valid/ready handshake.

---
 rtl/dmem_lsu_pkg.sv | 34 +++
 rtl/dmem_lsu_align.sv | 45 ++++
 rtl/dmem_lsu.sv | 146 ++++++++++++++
 tb/tb_dmem_lsu.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and lane-mask constants for the data-memory load/store unit.
// Byte/half/word sizes map to 1, 2 or 4 enabled byte lanes.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // The reserved size behaves as a word access.
  function automatic logic [3:0] base_mask(size_e s);
    logic [3:0] m;
    unique case (s)
      SZ_B:    m = MASK_B;
      SZ_H:    m = MASK_H;
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane shifting for stores and merge/extension for loads.
// Purely combinational; the top only sequences the two memory cycles.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [7:0]  mask_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [63:0] wide_w;
  logic [31:0] raw;
  logic        sx_b;
  logic        sx_h;

  assign sh     = {off_i, 3'b000};
  assign mask_o = {4'b0000, base_mask(size_i)} << off_i;

  // Bytes shifted past lane 3 land in the next word.
  assign wide_w     = {32'h0, wdata_i} << sh;
  assign wdata_lo_o = wide_w[31:0];
  assign wdata_hi_o = wide_w[63:32];

  assign raw  = 32'({hi_i, lo_i} >> sh);
  assign sx_b = ~uns_i & raw[7];
  assign sx_h = ~uns_i & raw[15];

  always_comb begin
    rdata_o = raw;
    unique case (size_i)
      SZ_B:    rdata_o = {{24{sx_b}}, raw[7:0]};
      SZ_H:    rdata_o = {{16{sx_h}}, raw[15:0]};
      default: rdata_o = raw;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator: one request at a time, split across two
// memory words when the access crosses a word boundary.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_q
);

  localparam int WI_W = ADDR_W - 2;
  localparam logic [WI_W-1:0] WI_ONE = WI_W'(1);

  state_e              state_q, state_d;
  size_e               size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;

  logic [7:0]          m;
  logic [DATA_W-1:0]   wd_lo;
  logic [DATA_W-1:0]   wd_hi;
  logic [DATA_W-1:0]   ld;
  logic                split;
  logic [WI_W-1:0]     widx;
  logic [WI_W-1:0]     widx_nxt;

  dmem_lsu_align u_align (
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .uns_i      (uns_q),
    .wdata_i    (wdata_q),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .mask_o     (m),
    .wdata_lo_o (wd_lo),
    .wdata_hi_o (wd_hi),
    .rdata_o    (ld)
  );

  assign split    = |m[7:4];
  assign widx     = addr_q[ADDR_W-1:2];
  assign widx_nxt = widx + WI_ONE;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wren  = 4'b0000;

    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted.
        o_req_ready = i_reset;
        if (i_req_valid) begin
          we_d    = i_req_we;
          uns_d   = i_req_unsigned;
          size_d  = size_e'(i_req_size);
          err_d   = (i_req_size == SZ_RSV);
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          state_d = ACC1;
        end
      end
      ACC1: begin
        o_mem_addr  = {widx, 2'b00};
        o_mem_wren  = we_q ? m[3:0] : 4'b0000;
        o_mem_wdata = wd_lo;
        hi_d        = '0;
        if (!we_q) lo_d = i_mem_q;
        state_d     = split ? ACC2 : RESP;
      end
      ACC2: begin
        o_mem_addr  = {widx_nxt, 2'b00};
        o_mem_wren  = we_q ? m[7:4] : 4'b0000;
        o_mem_wdata = wd_hi;
        if (!we_q) hi_d = i_mem_q;
        state_d     = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = we_q ? '0 : ld;
        o_rsp_err   = err_q;
        if (i_rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      size_q  <= SZ_B;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu with a byte-level memory model
// and a per-cycle expected-output queue.
module tb_dmem_lsu;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [10:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        i_rsp_ready = 1'b0;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [10:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wren;
  logic [31:0] i_mem_q;

  logic [7:0]  mem     [2048];
  logic [7:0]  ref_mem [2048];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic [10:0] a;
    logic [3:0]  wr;
    logic [31:0] wd;
  } exp_t;

  exp_t eq[$];

  dmem_lsu #(.ADDR_W(11), .DATA_W(32)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_wren     (o_mem_wren),
    .i_mem_q        (i_mem_q)
  );

  always #5 i_clk = ~i_clk;

  // Memory attached to the port: async read, write on the clock edge.
  logic [10:0] ba;
  assign ba = {o_mem_addr[10:2], 2'b00};
  assign i_mem_q = {mem[int'(ba) + 3], mem[int'(ba) + 2],
                    mem[int'(ba) + 1], mem[int'(ba)]};

  always @(posedge i_clk) begin
    for (int k = 0; k < 4; k++)
      if (o_mem_wren[k]) mem[int'(ba) + k] = o_mem_wdata[8*k +: 8];
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic exp_t mk(logic rdy, logic rv, logic [31:0] rd,
                              logic err, logic [10:0] a,
                              logic [3:0] wr, logic [31:0] wd);
    exp_t e;
    e.rdy = rdy; e.rv = rv; e.rd = rd; e.err = err;
    e.a = a; e.wr = wr; e.wd = wd;
    return e;
  endfunction

  // Where each byte of the store data lands, lane by lane.
  task automatic lanes(input logic [10:0] addr, input logic [1:0] size,
                       input logic [31:0] wd,
                       output logic [10:0] a0, output logic [10:0] a1,
                       output logic [3:0] w0, output logic [3:0] w1,
                       output logic [31:0] d0, output logic [31:0] d1);
    int off;
    int p;
    off = int'(addr) % 4;
    a0 = 11'(int'(addr) - off);
    a1 = 11'((int'(a0) + 4) % 2048);
    w0 = '0; w1 = '0; d0 = '0; d1 = '0;
    for (int j = 0; j < 4; j++) begin
      p = off + j;
      if (p < 4) d0[8*p +: 8] = wd[8*j +: 8];
      else       d1[8*(p-4) +: 8] = wd[8*j +: 8];
    end
    for (int i = 0; i < nbytes(size); i++) begin
      p = off + i;
      if (p < 4) w0[p] = 1'b1;
      else       w1[p-4] = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_load(logic [10:0] addr,
                                             logic [1:0] size,
                                             logic uns);
    int nb;
    logic [31:0] v;
    nb = nbytes(size);
    v = '0;
    for (int i = 0; i < nb; i++)
      v[8*i +: 8] = ref_mem[(int'(addr) + i) % 2048];
    if (!uns && nb < 4 && v[8*nb-1])
      for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_store(logic [10:0] addr, logic [1:0] size,
                             logic [31:0] wd, bit first_only);
    int off;
    off = int'(addr) % 4;
    for (int i = 0; i < nbytes(size); i++)
      if (!first_only || (off + i) < 4)
        ref_mem[(int'(addr) + i) % 2048] = wd[8*i +: 8];
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      exp_t e;
      if (eq.size() > 0) e = eq.pop_front();
      else e = mk(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
      check("req_ready", 32'(o_req_ready), 32'(e.rdy));
      check("rsp_valid", 32'(o_rsp_valid), 32'(e.rv));
      check("rsp_rdata", o_rsp_rdata, e.rd);
      check("rsp_err",   32'(o_rsp_err), 32'(e.err));
      check("mem_addr",  32'(o_mem_addr), 32'(e.a));
      check("mem_wren",  32'(o_mem_wren), 32'(e.wr));
      check("mem_wdata", o_mem_wdata, e.wd);
    end
  end

  // Called one time unit after a rising edge while the DUT is idle.
  task automatic do_txn(bit we, logic [1:0] size, bit uns,
                        logic [10:0] addr, logic [31:0] wd, int h);
    logic [10:0] a0, a1;
    logic [3:0]  w0, w1;
    logic [31:0] d0, d1, rd;
    bit split;
    lanes(addr, size, wd, a0, a1, w0, w1, d0, d1);
    split = (w1 != 4'b0000);
    rd = we ? 32'h0 : model_load(addr, size, uns);
    if (we) model_store(addr, size, wd, 1'b0);
    i_req_valid = 1'b1;
    i_req_we = we;
    i_req_size = size;
    i_req_unsigned = uns;
    i_req_addr = addr;
    i_req_wdata = wd;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_req_wdata = $urandom;
    eq.push_back(mk(1'b0, 1'b0, '0, 1'b0, a0, we ? w0 : 4'b0, d0));
    if (split)
      eq.push_back(mk(1'b0, 1'b0, '0, 1'b0, a1, we ? w1 : 4'b0, d1));
    for (int k = 0; k <= h; k++)
      eq.push_back(mk(1'b0, 1'b1, rd, size == 2'd3, '0, '0, '0));
    repeat ((split ? 2 : 1) + h) @(posedge i_clk);
    #1 i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [10:0] a0, a1;
  logic [3:0]  w0, w1;
  logic [31:0] d0, d1;
  logic [31:0] pre;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_req_ready", 32'(o_req_ready), 32'h0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'h0);
    check("rst_mem_addr", 32'(o_mem_addr), 32'h0);
    check("rst_mem_wren", 32'(o_mem_wren), 32'h0);
    check("rst_mem_wdata", o_mem_wdata, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    #1 check("rel_req_ready", 32'(o_req_ready), 32'h1);
    chk_en = 1'b1;
    @(posedge i_clk); #1;

    lanes(11'h010, 2'd2, 32'hDEADBEEF, a0, a1, w0, w1, d0, d1);
    check("pin_w_wren", 32'(w0), 32'hF);
    check("pin_w_wdata", d0, 32'hDEADBEEF);
    do_txn(1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF, 0);
    check("pin_w_load", model_load(11'h010, 2'd2, 1'b0), 32'hDEADBEEF);
    do_txn(1'b0, 2'd2, 1'b0, 11'h010, $urandom, 0);

    lanes(11'h013, 2'd0, 32'h00000080, a0, a1, w0, w1, d0, d1);
    check("pin_b_wren", 32'(w0), 32'h8);
    check("pin_b_wdata", d0, 32'h80000000);
    do_txn(1'b1, 2'd0, 1'b0, 11'h013, 32'h00000080, 0);
    check("pin_b_sx", model_load(11'h013, 2'd0, 1'b0), 32'hFFFFFF80);
    check("pin_b_zx", model_load(11'h013, 2'd0, 1'b1), 32'h00000080);
    do_txn(1'b0, 2'd0, 1'b0, 11'h013, $urandom, 0);
    do_txn(1'b0, 2'd0, 1'b1, 11'h013, $urandom, 0);

    lanes(11'h006, 2'd2, 32'h11223344, a0, a1, w0, w1, d0, d1);
    check("pin_mis_a0", 32'(a0), 32'h004);
    check("pin_mis_w0", 32'(w0), 32'hC);
    check("pin_mis_d0", d0, 32'h33440000);
    check("pin_mis_a1", 32'(a1), 32'h008);
    check("pin_mis_w1", 32'(w1), 32'h3);
    check("pin_mis_d1", d1, 32'h00001122);
    do_txn(1'b1, 2'd2, 1'b0, 11'h006, 32'h11223344, 0);
    do_txn(1'b0, 2'd2, 1'b0, 11'h006, $urandom, 0);

    lanes(11'h7FF, 2'd1, 32'h0000ABCD, a0, a1, w0, w1, d0, d1);
    check("pin_wrap_a0", 32'(a0), 32'h7FC);
    check("pin_wrap_w0", 32'(w0), 32'h8);
    check("pin_wrap_a1", 32'(a1), 32'h000);
    check("pin_wrap_w1", 32'(w1), 32'h1);
    do_txn(1'b1, 2'd1, 1'b0, 11'h7FF, 32'h0000ABCD, 0);
    check("pin_wrap_ld", model_load(11'h7FF, 2'd1, 1'b0), 32'hFFFFABCD);
    do_txn(1'b0, 2'd1, 1'b0, 11'h7FF, $urandom, 0);

    do_txn(1'b0, 2'd2, 1'b0, 11'h006, $urandom, 5);
    do_txn(1'b1, 2'd0, 1'b0, 11'h021, 32'h12345678, 5);
    do_txn(1'b1, 2'd3, 1'b0, 11'h102, 32'hCAFEF00D, 0);
    do_txn(1'b0, 2'd3, 1'b1, 11'h102, $urandom, 1);

    // Reset during the second half of a split store.
    lanes(11'h106, 2'd2, 32'h55667788, a0, a1, w0, w1, d0, d1);
    pre = {mem[11'h10B], mem[11'h10A], mem[11'h109], mem[11'h108]};
    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_size = 2'd2;
    i_req_unsigned = 1'b0;
    i_req_addr = 11'h106;
    i_req_wdata = 32'h55667788;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    eq.push_back(mk(1'b0, 1'b0, '0, 1'b0, a0, w0, d0));
    eq.push_back(mk(1'b0, 1'b0, '0, 1'b0, a1, w1, d1));
    @(posedge i_clk);
    @(negedge i_clk);
    #2 chk_en = 1'b0;
    i_reset = 1'b0;
    #1;
    check("arst_wren", 32'(o_mem_wren), 32'h0);
    check("arst_req_ready", 32'(o_req_ready), 32'h0);
    check("arst_mem_addr", 32'(o_mem_addr), 32'h0);
    check("arst_queue", 32'(eq.size()), 32'h0);
    model_store(11'h106, 2'd2, 32'h55667788, 1'b1);
    @(posedge i_clk); #1;
    check("arst_word1", {mem[11'h10B], mem[11'h10A], mem[11'h109],
                         mem[11'h108]}, pre);
    check("arst_word0", {mem[11'h107], mem[11'h106], mem[11'h105],
                         mem[11'h104]},
          {ref_mem[11'h107], ref_mem[11'h106], ref_mem[11'h105],
           ref_mem[11'h104]});
    i_reset = 1'b1;
    #1 check("arst_rel_ready", 32'(o_req_ready), 32'h1);
    chk_en = 1'b1;
    @(posedge i_clk); #1;
    do_txn(1'b0, 2'd2, 1'b0, 11'h106, $urandom, 0);
    do_txn(1'b0, 2'd2, 1'b0, 11'h10A, $urandom, 0);

    for (int t = 0; t < 400; t++) begin
      logic [10:0] addr;
      int h;
      if ($urandom_range(0, 3) == 0)
        addr = 11'(2047 - $urandom_range(0, 15));
      else
        addr = 11'($urandom_range(0, 47));
      h = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), addr,
             $urandom, h);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) @(posedge i_clk);
      #0;
    end

    repeat (3) @(posedge i_clk);
    #1 chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
